// File: rtl/multicore_run_monitor_pkg.sv
// Shared run-monitor types and the ENDOP opcode, also used by the processor decoder.
package run_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } run_state_t;

    localparam logic [7:0] ENDOP = 8'd28;

endpackage

// File: rtl/multicore_run_monitor_if.sv
// Host/core-array side bundle of the run monitor.
// RUN_MON_HALT_OUT_EN adds the per-core halt_req signal.
interface multicore_run_monitor_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned INS_W     = 8,
    parameter int unsigned CNT_W     = 24
);
    localparam int unsigned RD_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic                       start;
    logic [NUM_CORES*INS_W-1:0] ins;
    logic [NUM_CORES-1:0]       core_done;
    logic                       busy;
    logic                       all_done;
    logic                       timeout;
    logic [CNT_W-1:0]           cycle_count;
    logic [RD_W-1:0]            rd_sel;
    logic [CNT_W-1:0]           rd_cycle;
`ifdef RUN_MON_HALT_OUT_EN
    logic [NUM_CORES-1:0]       halt_req;

    modport master (
        output start, ins, rd_sel,
        input  core_done, busy, all_done, timeout, cycle_count, rd_cycle, halt_req
    );
    modport slave (
        input  start, ins, rd_sel,
        output core_done, busy, all_done, timeout, cycle_count, rd_cycle, halt_req
    );
`else
    modport master (
        output start, ins, rd_sel,
        input  core_done, busy, all_done, timeout, cycle_count, rd_cycle
    );
    modport slave (
        input  start, ins, rd_sel,
        output core_done, busy, all_done, timeout, cycle_count, rd_cycle
    );
`endif

endinterface

// File: rtl/multicore_run_monitor_core_slice.sv
// Per-core ENDOP detector: sticky done flag plus captured completion cycle.
module run_mon_core_slice
    import run_mon_pkg::*;
#(
    parameter int unsigned      INS_W    = 8,
    parameter logic [INS_W-1:0] ENDOP_OP = ENDOP,
    parameter int unsigned      CNT_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic [INS_W-1:0] ins_i,
    input  logic [CNT_W-1:0] cycle_i,
    output logic             done_o,
    output logic             hit_o,
    output logic [CNT_W-1:0] capture_o
);

    logic             done_q, done_d;
    logic [CNT_W-1:0] cap_q, cap_d;
    logic             hit;

    // Only the first ENDOP of a run counts; later ones leave the capture alone.
    assign hit = run_i && (ins_i == ENDOP_OP) && !done_q;

    always_comb begin
        done_d = done_q;
        cap_d  = cap_q;
        if (clear_i) begin
            done_d = 1'b0;
            cap_d  = '0;
        end else if (hit) begin
            done_d = 1'b1;
            cap_d  = cycle_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            cap_q  <= '0;
        end else begin
            done_q <= done_d;
            cap_q  <= cap_d;
        end
    end

    assign done_o    = done_q;
    assign hit_o     = hit;
    assign capture_o = cap_q;

endmodule

// File: rtl/multicore_run_monitor.sv
// Run-control and completion monitor for the core array.
// Optional macro RUN_MON_HALT_OUT_EN adds per-core halt_req.
module multicore_run_monitor
    import run_mon_pkg::*;
#(
    parameter int unsigned      NUM_CORES  = 4,
    parameter int unsigned      INS_W      = 8,
    parameter logic [INS_W-1:0] ENDOP_OP   = ENDOP,
    parameter int unsigned      CNT_W      = 24,
    parameter int unsigned      MAX_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicore_run_monitor_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    run_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, all_done_q, timeout_q;
    logic                 run, clear;
    logic [NUM_CORES-1:0] done_vec, hit_vec;
    logic [CNT_W-1:0]     cap [NUM_CORES];

    assign run   = (state_q == RUN);
    assign clear = bus.start && (state_q != RUN);

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slice
        run_mon_core_slice #(
            .INS_W    (INS_W),
            .ENDOP_OP (ENDOP_OP),
            .CNT_W    (CNT_W)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .run_i     (run),
            .clear_i   (clear),
            .ins_i     (bus.ins[g*INS_W +: INS_W]),
            .cycle_i   (cnt_q),
            .done_o    (done_vec[g]),
            .hit_o     (hit_vec[g]),
            .capture_o (cap[g])
        );
    end

    // Completion is checked before the budget so a last ENDOP on the final cycle wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (&(done_vec | hit_vec))
                    state_d = DONE;
                else if (cnt_q == LAST_CYCLE)
                    state_d = TIMEOUT;
            end
            default: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= (state_d == RUN);
            all_done_q <= (state_d == DONE);
            timeout_q  <= (state_d == TIMEOUT);
        end
    end

    assign bus.core_done   = done_vec;
    assign bus.busy        = busy_q;
    assign bus.all_done    = all_done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cnt_q;

    always_comb begin
        bus.rd_cycle = '0;
        if (int'(bus.rd_sel) < NUM_CORES)
            bus.rd_cycle = cap[bus.rd_sel];
    end

`ifdef RUN_MON_HALT_OUT_EN
    logic [NUM_CORES-1:0] halt_q, halt_d;

    always_comb begin
        halt_d = halt_q | hit_vec;
        if (clear)
            halt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halt_q <= '0;
        else
            halt_q <= halt_d;
    end

    assign bus.halt_req = halt_q | {NUM_CORES{timeout_q}};
`endif

endmodule

// File: tb/tb_multicore_run_monitor.sv
// Directed self-checking bench for multicore_run_monitor (4 cores, 50-cycle budget).
module tb_multicore_run_monitor;
    import run_mon_pkg::*;

    localparam int unsigned NC = 4;
    localparam int unsigned IW = 8;
    localparam int unsigned CW = 24;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    multicore_run_monitor_if #(.NUM_CORES(NC), .INS_W(IW), .CNT_W(CW)) bus ();

    multicore_run_monitor #(
        .NUM_CORES  (NC),
        .INS_W      (IW),
        .ENDOP_OP   (8'd28),
        .CNT_W      (CW),
        .MAX_CYCLES (50)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle(input logic [NC-1:0] mask);
        for (int i = 0; i < NC; i++)
            bus.ins[i*IW +: IW] = mask[i] ? 8'd28 : 8'(8'h40 + i);
        tick();
    endtask

    task automatic check_cap(input string tag, input int core, input logic [31:0] exp);
        bus.rd_sel = 2'(core);
        #1;
        check(tag, 32'(bus.rd_cycle), exp);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        run_cycle('0);
        bus.start = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.ins    = '0;
        bus.rd_sel = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle with ENDOP on every bus and no start
        bus.ins = {NC{8'd28}};
        repeat (3) tick();
        check("idle_core_done", 32'(bus.core_done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_all_done", 32'(bus.all_done), 32'd0);
        check("idle_timeout", 32'(bus.timeout), 32'd0);
        check("idle_count", 32'(bus.cycle_count), 32'd0);
        check_cap("idle_cap0", 0, 32'd0);

        // Staggered completion: cores 0,1,2,3 at cycles 5,9,9,20; core 0 keeps repeating ENDOP
        pulse_start();
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_count0", 32'(bus.cycle_count), 32'd0);
        for (int c = 0; c <= 20; c++) begin
            run_cycle({c == 20, c == 9, c == 9, c >= 5});
            if (c == 5) check("stag_done_c5", 32'(bus.core_done), 32'b0001);
`ifdef RUN_MON_HALT_OUT_EN
            if (c == 8) check("halt1_before", 32'(bus.halt_req[1]), 32'd0);
            if (c == 9) check("halt1_after", 32'(bus.halt_req[1]), 32'd1);
`endif
            if (c == 19) begin
                check("stag_done_c19", 32'(bus.core_done), 32'b0111);
                check("stag_alldone_c19", 32'(bus.all_done), 32'd0);
            end
        end
        check("stag_all_done", 32'(bus.all_done), 32'd1);
        check("stag_busy", 32'(bus.busy), 32'd0);
        check("stag_count", 32'(bus.cycle_count), 32'd21);
        check_cap("stag_cap0", 0, 32'd5);
        check_cap("stag_cap1", 1, 32'd9);
        check_cap("stag_cap2", 2, 32'd9);
        check_cap("stag_cap3", 3, 32'd20);
        run_cycle('1);
        run_cycle('0);
        check("stag_count_hold", 32'(bus.cycle_count), 32'd21);

        // Restart from DONE, start ignored in RUN, then timeout with core 3 silent
        pulse_start();
        check("rst_core_done", 32'(bus.core_done), 32'd0);
        check("rst_count", 32'(bus.cycle_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_all_done", 32'(bus.all_done), 32'd0);
        check_cap("rst_cap3", 3, 32'd0);
        for (int c = 0; c <= 2; c++)
            run_cycle({3'b000, c == 2});
        bus.start = 1'b1;
        run_cycle('0);
        bus.start = 1'b0;
        check("start_in_run_busy", 32'(bus.busy), 32'd1);
        check("start_in_run_count", 32'(bus.cycle_count), 32'd4);
        check("start_in_run_done", 32'(bus.core_done), 32'b0001);
        check_cap("start_in_run_cap0", 0, 32'd2);
        for (int c = 4; c <= 49; c++) begin
            run_cycle({1'b0, c == 10, c == 10, 1'b0});
            if (c == 48) check("to_before", 32'(bus.timeout), 32'd0);
        end
        check("to_timeout", 32'(bus.timeout), 32'd1);
        check("to_busy", 32'(bus.busy), 32'd0);
        check("to_all_done", 32'(bus.all_done), 32'd0);
        check("to_core_done", 32'(bus.core_done), 32'b0111);
        check("to_count", 32'(bus.cycle_count), 32'd50);
`ifdef RUN_MON_HALT_OUT_EN
        check("to_halt", 32'(bus.halt_req), 32'b1111);
`endif
        run_cycle('1);
        check("to_count_hold", 32'(bus.cycle_count), 32'd50);
        check("to_ins_ignored", 32'(bus.core_done), 32'b0111);

        // Tie: last ENDOP on the final budget cycle
        pulse_start();
        check("tie_timeout_clr", 32'(bus.timeout), 32'd0);
        for (int c = 0; c <= 49; c++)
            run_cycle({c == 49, {3{c == 10}}});
        check("tie_all_done", 32'(bus.all_done), 32'd1);
        check("tie_timeout", 32'(bus.timeout), 32'd0);
        check("tie_count", 32'(bus.cycle_count), 32'd50);
        check_cap("tie_cap3", 3, 32'd49);
        check_cap("tie_cap0", 0, 32'd10);

        // Asynchronous reset in the middle of a run
        pulse_start();
        for (int c = 0; c <= 4; c++)
            run_cycle({3'b000, c == 2});
        check_cap("pre_reset_cap0", 0, 32'd2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_count", 32'(bus.cycle_count), 32'd0);
        check("async_core_done", 32'(bus.core_done), 32'd0);
        check_cap("async_cap0", 0, 32'd0);
        #1 rst_n = 1'b1;
        run_cycle('0);
        check("post_reset_busy", 32'(bus.busy), 32'd0);
        check("post_reset_count", 32'(bus.cycle_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/multicore_run_monitor.md
Name: multicore_run_monitor

Overview:
- Synthesizable run-control and completion monitor for the multi-core processor array.
- Watches each core's instruction bus for the ENDOP opcode and records each core's completion cycle.
- Flags global completion, or a timeout if the run exceeds a cycle budget.
- Sits beside the core array in the top level; the bench and the host read status from it.

Parameters:
- NUM_CORES, 4, number of monitored cores (≥1)
- INS_W, 8, instruction width per core
- ENDOP_OP, 8'd28, opcode marking end of program
- CNT_W, 24, width of cycle counter and captured cycle values
- MAX_CYCLES, 100000, timeout budget in RUN cycles (< 2^CNT_W)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a run
- ins  in  NUM_CORES*INS_W  packed per-core instruction buses; core i occupies bits [i*INS_W +: INS_W]
- core_done  out  NUM_CORES  sticky per-core ENDOP seen
- busy  out  1  high while in RUN
- all_done  out  1  high in DONE
- timeout  out  1  high in TIMEOUT
- cycle_count  out  CNT_W  cycles elapsed in current/last run
- rd_sel  in  $clog2(NUM_CORES) (min 1)  core index for readback
- rd_cycle  out  CNT_W  captured completion cycle of core rd_sel; combinational mux

Behaviour:
- Single clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE; core_done=0; busy=0; all_done=0; timeout=0; cycle_count=0; all captured cycles=0.
- FSM states: IDLE, RUN, DONE, TIMEOUT; encoding is a 2-bit enum.
- IDLE: start=1 → RUN at next edge. On that same edge: cycle_count←0, core_done←0, captures←0.
- RUN: each edge, cycle_count increments by 1. The first RUN cycle observes cycle_count=0.
- RUN, per core i: if ins slice == ENDOP_OP and core_done[i]==0, then on that edge core_done[i]←1 and capture[i]←cycle_count (pre-increment value). Later ENDOPs on a done core are ignored.
- RUN → DONE at the edge where (core_done | newly detected) is all ones. cycle_count holds its value from then on.
- RUN → TIMEOUT at the edge where cycle_count == MAX_CYCLES-1 and not all done.
- Simultaneous last ENDOP and timeout edge: DONE wins; timeout stays 0.
- start in RUN: ignored.
- start in DONE or TIMEOUT: re-enters RUN with the same clears as from IDLE. Status flags drop on that edge.
- Flag decoding: busy=(state==RUN), all_done=(state==DONE), timeout=(state==TIMEOUT), all registered/state-decoded. Latency from the last ENDOP sample to all_done=1 is 1 cycle.
- Counter never wraps: TIMEOUT is reached before saturation.
- ins values in IDLE/DONE/TIMEOUT are ignored.
- Reset asserted mid-RUN: immediate return to reset values, independent of clk.
- rd_sel ≥ NUM_CORES: rd_cycle=0.

Optional Feature:
- Macro: RUN_MON_HALT_OUT_EN.
- Defined: adds output halt_req [NUM_CORES-1:0]. halt_req[i]=1 in the cycle after core i's ENDOP detection, and stays 1 until the next start or reset. In TIMEOUT all bits are forced to 1.
- Undefined: port absent and no halt logic; all other behaviour identical.

Decomposition:
- Shared package run_mon_pkg: run_state_t enum {IDLE, RUN, DONE, TIMEOUT}; ENDOP opcode constant (8'd28), shared with the processor decoder.
- One natural sub-module: run_mon_core_slice, instantiated per core via generate. It holds the opcode compare, sticky done flag and capture register, driven by common run/clear/cycle_count inputs.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then ins all 28 with no start → all outputs 0, state IDLE.
- Staggered completion (NUM_CORES=4): start, then ENDOP on cores 0,1,2,3 at RUN cycles 5,9,9,20 → captures 5,9,9,20; all_done=1 one cycle after cycle 20; cycle_count holds 21.
- Timeout: MAX_CYCLES=50, core 3 never ENDOPs → timeout=1 after 50 RUN cycles; core_done=4'b0111; busy=0.
- Tie: last ENDOP in the cycle where cycle_count==MAX_CYCLES-1 → all_done=1, timeout=0.
- Restart/robustness: start in DONE clears core_done and cycle_count to 0 and busy=1. Repeated ENDOP on core 0 does not move its capture. start in RUN is ignored. rst_n pulse mid-RUN returns to IDLE asynchronously.
- RUN_MON_HALT_OUT_EN build: halt_req[1] rises one cycle after core 1's ENDOP. On timeout, halt_req=4'b1111.
